// File: rtl/counter_sampler.sv
// Two-beat read initiator for the 64-bit atomic event counter; presents {hi, lo} on valid/ready.
// Optional macro COUNTER_SAMPLER_DELTA_EN adds delta_o = sample - previous accepted sample.
module counter_sampler #(
  parameter int unsigned DATABUS = 32,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   req_o,
  output logic                   atomic_o,
  input  logic                   ack_i,
  input  logic [DATABUS-1:0]     count_i,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [2*DATABUS-1:0]   sample_o,
  output logic                   err_o
`ifdef COUNTER_SAMPLER_DELTA_EN
  ,
  output logic [2*DATABUS-1:0]   delta_o
`endif
);

  localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned SAMPLE_W = 2 * DATABUS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LO,
    S_ISSUE_HI,
    S_COLLECT,
    S_PRESENT
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                atomic_q, atomic_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                lo_seen_q, lo_seen_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATABUS-1:0]  lo_q, lo_d;
  logic [DATABUS-1:0]  hi_q, hi_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      atomic_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      lo_seen_q <= 1'b0;
      wait_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      atomic_q  <= atomic_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      lo_seen_q <= lo_seen_d;
      wait_q    <= wait_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
    end
  end

  // Next-state, ack capture and timeout; outputs are decoded from the next state
  always_comb begin
    state_d   = state_q;
    lo_seen_d = lo_seen_q;
    wait_d    = wait_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_ISSUE_LO;
          lo_seen_d = 1'b0;
          wait_d    = '0;
        end
      end
      S_ISSUE_LO: begin
        state_d = S_ISSUE_HI;
      end
      S_ISSUE_HI: begin
        state_d = S_COLLECT;
        if (ack_i) begin
          lo_d      = count_i;
          lo_seen_d = 1'b1;
        end
      end
      S_COLLECT: begin
        if (ack_i && lo_seen_q) begin
          hi_d    = count_i;
          state_d = S_PRESENT;
        end else if (wait_q >= WAIT_W'(TIMEOUT - 1)) begin
          // Timed out: drop whatever was captured and return without a sample
          err_d     = 1'b1;
          state_d   = S_IDLE;
          lo_d      = '0;
          hi_d      = '0;
          lo_seen_d = 1'b0;
        end else begin
          if (ack_i) begin
            lo_d      = count_i;
            lo_seen_d = 1'b1;
          end
          wait_d = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + WAIT_W'(1);
        end
      end
      S_PRESENT: begin
        if (valid_q && sample_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_d    = (state_d == S_ISSUE_LO) || (state_d == S_ISSUE_HI);
    atomic_d = (state_d == S_ISSUE_LO);
    busy_d   = (state_d != S_IDLE);
    valid_d  = (state_d == S_PRESENT);
  end

  assign busy_o         = busy_q;
  assign req_o          = req_q;
  assign atomic_o       = atomic_q;
  assign sample_valid_o = valid_q;
  assign err_o          = err_q;
  assign sample_o       = {hi_q, lo_q};

`ifdef COUNTER_SAMPLER_DELTA_EN
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic [SAMPLE_W-1:0] delta_q, delta_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      delta_q <= '0;
    end else begin
      prev_q  <= prev_d;
      delta_q <= delta_d;
    end
  end

  // Delta is computed as the sample completes; previous advances only on handshake
  always_comb begin
    prev_d  = prev_q;
    delta_d = delta_q;
    if (state_q == S_COLLECT && ack_i && lo_seen_q) begin
      delta_d = {count_i, lo_q} - prev_q;
    end
    if (state_q == S_PRESENT && valid_q && sample_ready_i) begin
      prev_d = {hi_q, lo_q};
    end
  end

  assign delta_o = delta_q;
`endif

endmodule

// File: tb/tb_counter_sampler.sv
// Directed self-checking bench for counter_sampler (delta checks when COUNTER_SAMPLER_DELTA_EN is defined).
module tb_counter_sampler;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic        busy_o;
  logic        req_o;
  logic        atomic_o;
  logic        ack_i;
  logic [31:0] count_i;
  logic        sample_valid_o;
  logic        sample_ready_i;
  logic [63:0] sample_o;
  logic        err_o;
`ifdef COUNTER_SAMPLER_DELTA_EN
  logic [63:0] delta_o;
`endif

  int tests;
  int fails;

  counter_sampler #(.DATABUS(32), .TIMEOUT(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .req_o          (req_o),
    .atomic_o       (atomic_o),
    .ack_i          (ack_i),
    .count_i        (count_i),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .sample_o       (sample_o),
    .err_o          (err_o)
`ifdef COUNTER_SAMPLER_DELTA_EN
    ,
    .delta_o        (delta_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs a read with acks in cycles 2 and 3; returns positioned in the first PRESENT cycle
  task automatic do_read(input logic [31:0] lo, input logic [31:0] hi);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    ack_i   = 1'b1;
    count_i = lo;
    step();
    count_i = hi;
    step();
    ack_i   = 1'b0;
    count_i = '0;
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset_n        = 1'b0;
    start_i        = 1'b0;
    ack_i          = 1'b0;
    count_i        = '0;
    sample_ready_i = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    chk("rst_busy",   64'(busy_o), 64'd0);
    chk("rst_req",    64'(req_o), 64'd0);
    chk("rst_atomic", 64'(atomic_o), 64'd0);
    chk("rst_valid",  64'(sample_valid_o), 64'd0);
    chk("rst_err",    64'(err_o), 64'd0);
    chk("rst_sample", sample_o, 64'd0);

    // Basic read with cycle-by-cycle request pattern
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("c1_req",    64'(req_o), 64'd1);
    chk("c1_atomic", 64'(atomic_o), 64'd1);
    chk("c1_busy",   64'(busy_o), 64'd1);
    step();
    chk("c2_req",    64'(req_o), 64'd1);
    chk("c2_atomic", 64'(atomic_o), 64'd0);
    ack_i   = 1'b1;
    count_i = 32'h0000_0005;
    step();
    chk("c3_req",   64'(req_o), 64'd0);
    chk("c3_valid", 64'(sample_valid_o), 64'd0);
    count_i = 32'h0000_0001;
    step();
    ack_i   = 1'b0;
    count_i = '0;
    chk("c4_valid",  64'(sample_valid_o), 64'd1);
    chk("c4_sample", sample_o, 64'h0000_0001_0000_0005);
    chk("c4_busy",   64'(busy_o), 64'd1);
    sample_ready_i = 1'b1;
    step();
    sample_ready_i = 1'b0;
    chk("c5_valid", 64'(sample_valid_o), 64'd0);
    chk("c5_busy",  64'(busy_o), 64'd0);

    // Backpressure: held sample, ignored start pulses and stale acks
    do_read(32'h0000_AAAA, 32'h0000_0002);
    chk("bp_valid0",  64'(sample_valid_o), 64'd1);
    chk("bp_sample0", sample_o, 64'h0000_0002_0000_AAAA);
    for (int i = 0; i < 5; i++) begin
      start_i = 1'b1;
      ack_i   = 1'b1;
      count_i = 32'h0000_DEAD;
      step();
      chk("bp_valid",  64'(sample_valid_o), 64'd1);
      chk("bp_sample", sample_o, 64'h0000_0002_0000_AAAA);
      chk("bp_req",    64'(req_o), 64'd0);
    end
    start_i        = 1'b0;
    ack_i          = 1'b0;
    count_i        = '0;
    sample_ready_i = 1'b1;
    step();
    sample_ready_i = 1'b0;
    chk("bp_done_valid", 64'(sample_valid_o), 64'd0);
    chk("bp_done_busy",  64'(busy_o), 64'd0);
    step();
    chk("bp_no_queue", 64'(busy_o), 64'd0);

    // Timeout: hi ack never arrives
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    ack_i   = 1'b1;
    count_i = 32'h0000_0033;
    step();
    ack_i   = 1'b0;
    count_i = '0;
    for (int c = 3; c <= 10; c++) begin
      chk("to_err_low", 64'(err_o), 64'd0);
      chk("to_busy",    64'(busy_o), 64'd1);
      step();
    end
    chk("to_err_pulse", 64'(err_o), 64'd1);
    chk("to_busy_end",  64'(busy_o), 64'd0);
    chk("to_valid",     64'(sample_valid_o), 64'd0);
    chk("to_discard",   sample_o, 64'd0);
    step();
    chk("to_err_clear", 64'(err_o), 64'd0);

    // Reset in ISSUE_HI, then a late ack
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    chk("mr_req_pre", 64'(req_o), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_req",    64'(req_o), 64'd0);
    chk("mr_atomic", 64'(atomic_o), 64'd0);
    chk("mr_busy",   64'(busy_o), 64'd0);
    step();
    reset_n = 1'b1;
    ack_i   = 1'b1;
    count_i = 32'h0000_0007;
    step();
    ack_i   = 1'b0;
    count_i = '0;
    chk("mr_late_valid",  64'(sample_valid_o), 64'd0);
    chk("mr_late_busy",   64'(busy_o), 64'd0);
    chk("mr_late_sample", sample_o, 64'd0);
    step();
    chk("mr_idle_valid", 64'(sample_valid_o), 64'd0);

`ifdef COUNTER_SAMPLER_DELTA_EN
    // Delta across counter wrap, starting from reset
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    do_read(32'hFFFF_FFF0, 32'hFFFF_FFFF);
    chk("dl_sample1", sample_o, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("dl_delta1",  delta_o, 64'hFFFF_FFFF_FFFF_FFF0);
    sample_ready_i = 1'b1;
    step();
    sample_ready_i = 1'b0;
    do_read(32'h0000_0010, 32'h0000_0000);
    chk("dl_sample2", sample_o, 64'h0000_0000_0000_0010);
    chk("dl_delta2",  delta_o, 64'h0000_0000_0000_0020);
    sample_ready_i = 1'b1;
    step();
    sample_ready_i = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_sampler.md
# counter_sampler

Read-side initiator for the 64-bit atomic event counter. On each `start_i` it issues the two-beat 32-bit read sequence: low word with `atomic` set, then high word with `atomic` clear. It assembles the 64-bit sample and presents it on a valid/ready output to the consumer, such as a statistics block or CSR mirror. It sits between the counter's `req`/`atomic`/`ack`/`count` port and the consumer.

## Interface
- `DATABUS`, 32, width of the counter read bus.
- `TIMEOUT`, 8, max cycles to wait for an outstanding ack in COLLECT (≥2).
- `clk` input 1 — single clock, all logic on rising edge.
- `reset_n` input 1 — asynchronous, active-low reset.
- `start_i` input 1 — sample request; accepted only in IDLE.
- `busy_o` output 1 — high in every state except IDLE.
- `req_o` output 1 — counter read request, registered.
- `atomic_o` output 1 — high = low-word read, low = high-word read.
- `ack_i` input 1 — counter read acknowledge, one cycle after `req_o`.
- `count_i` input DATABUS — counter read data, valid when `ack_i`=1.
- `sample_valid_o` output 1 — assembled sample available.
- `sample_ready_i` input 1 — consumer accepts the sample.
- `sample_o` output 2*DATABUS — assembled count {hi, lo}.
- `err_o` output 1 — one-cycle pulse when a read times out.

## Operation
- FSM states:
  - IDLE: if `start_i`, go to ISSUE_LO.
  - ISSUE_LO: drive `req_o`=1, `atomic_o`=1, then go to ISSUE_HI.
  - ISSUE_HI: drive `req_o`=1, `atomic_o`=0, then go to COLLECT.
  - COLLECT: wait for the outstanding acks. When both are seen, go to PRESENT.
  - PRESENT: hold the sample until `sample_valid_o && sample_ready_i`, then go to IDLE.
- Acks are counted from ISSUE_HI onward:
  - First `ack_i` captures `count_i` into the lo register.
  - Second `ack_i` captures `count_i` into the hi register.
- `sample_o` = {hi, lo}. It is stable while `sample_valid_o`=1.
- Timeout: in COLLECT, a wait counter increments each cycle without ack completion. If it reaches `TIMEOUT`:
  - pulse `err_o` for one cycle;
  - discard partial data;
  - go to IDLE with no sample presented.
- Ignored inputs:
  - `ack_i` in IDLE, ISSUE_LO or PRESENT, and any third `ack_i`, are ignored (stale acks).
  - `start_i` while `busy_o`=1 is ignored and not queued.
- Reset (async, any state):
  - state goes to IDLE;
  - `req_o`, `atomic_o`, `busy_o`, `sample_valid_o` and `err_o` go to 0;
  - `sample_o` and all capture/delta registers go to 0.
  - An ack arriving after reset deasserts is a stale ack and is ignored.

## Timing
- Cycle 0: `start_i`=1 in IDLE.
- Cycle 1: `req_o`=1, `atomic_o`=1.
- Cycle 2: `req_o`=1, `atomic_o`=0; lo ack expected.
- Cycle 3: `req_o`=0; hi ack expected.
- Cycle 4: `sample_valid_o`=1.
- Minimum start-to-valid latency is 4 cycles.
- If the consumer is ready immediately, the next `start_i` is accepted in cycle 5.
- `req_o` is high for exactly two consecutive cycles per transaction, and is never high outside ISSUE_LO and ISSUE_HI.
- Backpressure: `sample_valid_o` stays high and `sample_o` stays constant until the handshake. The transfer completes in the cycle where valid and ready are both high.
- Arithmetic:
  - the wait counter is $clog2(TIMEOUT+1) bits, saturating;
  - sample assembly is a pure concatenation with no carry correction.

## Configuration
- `COUNTER_SAMPLER_DELTA_EN` defined:
  - adds output `delta_o` [2*DATABUS-1:0] = current sample − previous accepted sample, modulo 2^(2*DATABUS).
  - `delta_o` is valid alongside `sample_o`.
  - The previous sample updates only on a completed handshake.
  - The first sample after reset yields `delta_o` = `sample_o` (previous = 0).
  - Counter wrap yields the correct modular difference.
- Not defined: no `delta_o` port and no previous-sample register; all other behaviour is identical.

## Test plan
- Basic read: counter responder returns lo=0x0000_0005 at cycle 2 and hi=0x0000_0001 at cycle 3 -> `sample_o`=0x0000_0001_0000_0005 and `sample_valid_o`=1 at cycle 4; `req_o` pattern 1,1,0 with `atomic_o` 1,0.
- Backpressure: `sample_ready_i`=0 for 5 cycles after valid -> `sample_o` constant, `sample_valid_o` held, `start_i` pulses ignored; ready=1 -> IDLE next cycle.
- Timeout: responder drops the hi ack -> `err_o` one-cycle pulse `TIMEOUT` cycles into COLLECT, no `sample_valid_o`, `busy_o`=0 after.
- Reset mid-read: `reset_n`=0 in ISSUE_HI -> all outputs 0 immediately; a late ack after release -> ignored, no sample.
- Delta with macro: samples 0xFFFF_FFFF_FFFF_FFF0 then 0x0000_0000_0000_0010 -> second `delta_o`=0x20; first `delta_o` equals first sample.
